attention_job_scheduler: RTL and testbench



---
 rtl/attention_job_scheduler_pkg.sv | 26 ++
 rtl/attention_job_scheduler_rr_arbiter.sv | 53 +++++
 rtl/attention_job_scheduler.sv | 161 ++++++++++++++++
 tb/tb_attention_job_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/attention_job_scheduler_pkg.sv
// Shared types and constants for the attention job scheduler.
package attn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ARST,
    WLOAD,
    START,
    RUN,
    DONE
  } sched_state_e;

  // Array geometry used to derive the nominal array latency.
  localparam int ATTN_N = 4;
  localparam int ATTN_K = 4;

  // Cycles from valid_input to valid_result for the shared array.
  localparam int EXP_LAT = 4 * ATTN_N + ATTN_K + 3;

  // Index width for a vector of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/attention_job_scheduler_rr_arbiter.sv
// Round-robin one-hot picker: the first set request at or after the pointer,
// wrapping. The pointer moves one past the served index when a job retires.
module rr_arbiter
  import attn_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IW-1:0]      adv_idx,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Position i steps after the pointer, wrapped into 0..NUM_REQ-1.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Scan from farthest to nearest so the nearest hit overwrites the others.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap_idx(ptr_q, i)]) begin
        gnt                     = '0;
        gnt[wrap_idx(ptr_q, i)] = 1'b1;
        gnt_idx                 = wrap_idx(ptr_q, i);
      end
    end
  end

  // Next pointer: one past the retiring owner.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = (int'(adv_idx) == NUM_REQ - 1) ? '0 : adv_idx + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/attention_job_scheduler.sv
// Time-shares one attention systolic array between NUM_REQ requesters.
// Each job: arbitrate, pulse the array reset to re-arm weight load, wait the
// weight-load time, strobe valid_input, wait for valid_result, pulse done.
// Optional watchdog in RUN is enabled by defining ATTN_SCHED_TIMEOUT_EN.
module attention_job_scheduler
  import attn_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int N              = 4,
  parameter int K              = 4,
  parameter int WLOAD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IW            = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [IW-1:0]      sel_id,
  output logic               busy,
  output logic               arr_reset,
  output logic               arr_valid_input,
  input  logic               arr_valid_result,
  output logic               err_timeout
);

  localparam int WW = idx_w(WLOAD_CYCLES + 1);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic               arst_q, arst_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               advance;

`ifdef ATTN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] run_cnt_q, run_cnt_d;
  logic          err_q, err_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .adv_idx (sel_q),
    .gnt     (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Job sequencing: next state, owner capture, weight-load and run counters.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    wcnt_d    = wcnt_q;
    advance   = 1'b0;
`ifdef ATTN_SCHED_TIMEOUT_EN
    run_cnt_d = run_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        // A request that vanished before arbitration abandons the job quietly.
        if (|req) begin
          grant_d = pick_oh;
          sel_d   = pick_idx;
          state_d = ARST;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      ARST: begin
        wcnt_d  = '0;
        state_d = WLOAD;
      end
      WLOAD: begin
        if (wcnt_q == WW'(WLOAD_CYCLES - 1)) state_d = START;
        else                                 wcnt_d  = wcnt_q + 1'b1;
      end
      START: begin
`ifdef ATTN_SCHED_TIMEOUT_EN
        run_cnt_d = '0;
`endif
        state_d = RUN;
      end
      RUN: begin
        // A result on the final watchdog cycle still counts as success.
        if (arr_valid_result) state_d = DONE;
`ifdef ATTN_SCHED_TIMEOUT_EN
        else if (run_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else run_cnt_d = run_cnt_q + 1'b1;
`endif
      end
      DONE: begin
        grant_d = '0;
        advance = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arst_d = (state_d == ARST);
  end

  // State and owner registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      arst_q  <= 1'b1;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      arst_q  <= arst_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef ATTN_SCHED_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      err_q     <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign grant           = grant_q;
  assign sel_id          = sel_q;
  assign busy            = (state_q != IDLE);
  assign arr_reset       = arst_q;
  assign arr_valid_input = (state_q == START);
  assign done            = (state_q == DONE) ? (NUM_REQ'(1) << sel_q) : '0;

  // The owner must hold its request until its done pulse.
  owner_holds_req: assert property (@(posedge clk) disable iff (reset)
    (state_q inside {ARST, WLOAD, START, RUN}) |-> req[sel_q]);

  // The watchdog must outlast a healthy array job.
  cfg_timeout_ok: assert property (@(posedge clk) disable iff (reset)
    TIMEOUT_CYCLES > 4 * N + K + 3);

endmodule

// File: tb/tb_attention_job_scheduler.sv
// Randomized bench for attention_job_scheduler with a job-level reference
// model (round-robin pick from the pending set, fixed per-phase timeline).
module tb_attention_job_scheduler;
  import attn_sched_pkg::*;

  localparam int NR = 4;
  localparam int W  = 4;
  localparam int TO = 64;
`ifdef ATTN_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR-1:0] grant, done;
  logic [1:0]    sel_id;
  logic          busy, arr_reset, arr_valid_input, arr_valid_result, err_timeout;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [NR-1:0] pend   = '0;
  int            ptr    = 0;
  bit            err_m  = 1'b0;

  attention_job_scheduler #(
    .NUM_REQ(NR), .N(4), .K(4), .WLOAD_CYCLES(W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .grant            (grant),
    .done             (done),
    .sel_id           (sel_id),
    .busy             (busy),
    .arr_reset        (arr_reset),
    .arr_valid_input  (arr_valid_input),
    .arr_valid_result (arr_valid_result),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first pending requester at or after the pointer.
  function automatic int pick(input logic [NR-1:0] p, input int pt);
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (pt + i) % NR;
      if (((p >> k) & 4'b1) != 0) return k;
    end
    return -1;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sel", 32'(sel_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_arst", 32'(arr_reset), 1);
    chk("rst_vi", 32'(arr_valid_input), 0);
    chk("rst_err", 32'(err_timeout), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    arr_valid_result = 1'b0;
    step();
    chk_reset_vals();
    reset = 1'b0;
    ptr   = 0;
    err_m = 1'b0;
  endtask

  // One job from an IDLE cycle with req already driven. lat = RUN cycle on
  // which the array answers; abort_at > 0 resets on that RUN cycle instead.
  task automatic do_job(input int lat, input bit keep, input bit spur,
                        input int abort_at, output int w);
    int  end_j;
    bit  exp_to;
    w = pick(pend, ptr);
    chk("idle_busy", 32'(busy), 0);
    step();
    chk("arb_busy", 32'(busy), 1);
    chk("arb_grant", 32'(grant), 0);
    chk("arb_arst", 32'(arr_reset), 0);
    step();
    chk("arst_pulse", 32'(arr_reset), 1);
    chk("arst_grant", 32'(grant), 1 << w);
    chk("arst_sel", 32'(sel_id), w);
    chk("arst_vi", 32'(arr_valid_input), 0);
    for (int i = 0; i < W; i++) begin
      step();
      arr_valid_result = 1'b0;
      chk("wload_arst", 32'(arr_reset), 0);
      chk("wload_vi", 32'(arr_valid_input), 0);
      chk("wload_done", 32'(done), 0);
      if (spur && i == 0) arr_valid_result = 1'b1;
    end
    step();
    arr_valid_result = 1'b0;
    chk("start_vi", 32'(arr_valid_input), 1);
    chk("start_arst", 32'(arr_reset), 0);
    chk("start_grant", 32'(grant), 1 << w);
    exp_to = TO_EN && (lat > TO);
    end_j  = exp_to ? TO : lat;
    for (int j = 1; j <= end_j; j++) begin
      step();
      arr_valid_result = 1'b0;
      chk("run_vi", 32'(arr_valid_input), 0);
      chk("run_done", 32'(done), 0);
      chk("run_grant", 32'(grant), 1 << w);
      chk("run_err", 32'(err_timeout), 32'(err_m));
      if (j == abort_at) begin
        do_reset();
        return;
      end
      if (j == lat) arr_valid_result = 1'b1;
    end
    step();
    arr_valid_result = 1'b0;
    if (exp_to) err_m = 1'b1;
    chk("done_pulse", 32'(done), 1 << w);
    chk("done_grant", 32'(grant), 1 << w);
    chk("done_busy", 32'(busy), 1);
    chk("done_err", 32'(err_timeout), 32'(err_m));
    ptr = (w + 1) % NR;
    if (!keep) pend[w] = 1'b0;
    req = pend;
    step();
    chk("post_busy", 32'(busy), 0);
    chk("post_grant", 32'(grant), 0);
    chk("post_done", 32'(done), 0);
  endtask

  initial begin
    int w;
    int order[5] = '{0, 1, 2, 3, 0};
    int prev_w;

    reset = 1'b1;
    req = '0;
    arr_valid_result = 1'b0;
    step();
    step();
    chk_reset_vals();
    reset = 1'b0;
    step();
    chk("rel_arst", 32'(arr_reset), 0);

    // All four requesting continuously: strict rotation, never repeats.
    pend = 4'hF;
    req  = pend;
    prev_w = -1;
    for (int n = 0; n < 5; n++) begin
      do_job(EXP_LAT, 1'b1, 1'b0, 0, w);
      chk("rr_order", w, order[n]);
      chk("rr_no_repeat", 32'(w == prev_w), 0);
      prev_w = w;
    end
    pend = '0;
    req  = '0;
    step();

    // Single requester with nominal array latency.
    pend = 4'b0010;
    req  = pend;
    do_job(EXP_LAT, 1'b0, 1'b1, 0, w);
    chk("single_id", w, 1);

    // Request withdrawn during arbitration: no job, no array reset.
    req = 4'b0001;
    step();
    chk("drop_arb_busy", 32'(busy), 1);
    req = '0;
    step();
    chk("drop_busy", 32'(busy), 0);
    chk("drop_grant", 32'(grant), 0);
    chk("drop_arst", 32'(arr_reset), 0);
    step();
    chk("drop_arst2", 32'(arr_reset), 0);

    // Reset during RUN, then the held request is served afresh.
    pend = 4'b0100;
    req  = pend;
    do_job(30, 1'b0, 1'b0, 5, w);
    do_job(EXP_LAT, 1'b0, 1'b0, 0, w);
    chk("after_rst_id", w, 2);

    // Randomized traffic with idle gaps and stray results.
    for (int n = 0; n < 30; n++) begin
      if (pend == '0) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          arr_valid_result = 1'($urandom % 2);
          step();
          arr_valid_result = 1'b0;
          chk("gap_busy", 32'(busy), 0);
          chk("gap_done", 32'(done), 0);
        end
        pend = 4'($urandom_range(1, 15));
      end else begin
        pend = pend | 4'($urandom);
      end
      req = pend;
      do_job($urandom_range(1, 40), ($urandom % 4) == 0, 1'($urandom % 2), 0, w);
    end
    pend = '0;
    req  = '0;
    step();

`ifdef ATTN_SCHED_TIMEOUT_EN
    // Array never answers: watchdog fires, owner released, next one served.
    pend = 4'b0011;
    req  = pend;
    do_job(1000, 1'b0, 1'b0, 0, w);
    chk("to_err_set", 32'(err_timeout), 1);
    do_job(EXP_LAT, 1'b0, 1'b0, 0, w);
    chk("to_sticky", 32'(err_timeout), 1);
    do_reset();
    // Result on the last allowed cycle wins over the watchdog.
    pend = 4'b1000;
    req  = pend;
    do_job(TO, 1'b0, 1'b0, 0, w);
    chk("to_edge_err", 32'(err_timeout), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
